// File: rtl/mux_pkg.sv
// Shared constants and types for the bus-wide 2:1 mux and its optional select counter.
package mux_pkg;

    localparam logic MUX_SEL_IN0 = 1'b0;
    localparam logic MUX_SEL_IN1 = 1'b1;
    localparam int   SEL_COUNT_W = 16;

    typedef logic [SEL_COUNT_W-1:0] sel_count_t;

endpackage

// File: rtl/mux2_bit.sv
// Single-bit 2:1 mux slice; the top replicates it once per data bit.
module mux2_bit
    import mux_pkg::*;
(
    output logic out,
    input  logic in0,
    input  logic in1,
    input  logic sel
);

    // An unknown sel propagates X rather than silently picking a side.
    assign out = (sel == MUX_SEL_IN1) ? in1 : in0;

endmodule

// File: rtl/mux_2to1.sv
// Bit-sliced WIDTH-bit 2:1 mux with a combinational output and a load-enabled registered copy.
// Defining MUX2_1_SEL_COUNT_EN adds sel1_count, a saturating count of loads taken with sel=1.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
`ifdef MUX2_1_SEL_COUNT_EN
    ,
    output logic [SEL_COUNT_W-1:0] sel1_count
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_bit u_bit (
            .out (out[i]),
            .in0 (in0[i]),
            .in1 (in1[i]),
            .sel (sel)
        );
    end

    // ---- registered stage: captures the combinational result on load ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            sel_q <= MUX_SEL_IN0;
        end else if (load) begin
            out_q <= out;
            sel_q <= sel;
        end
    end

`ifdef MUX2_1_SEL_COUNT_EN
    function automatic sel_count_t sat_inc(input sel_count_t v);
        return (v == '1) ? v : sel_count_t'(v + 1'b1);
    endfunction

    sel_count_t count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load && (sel == MUX_SEL_IN1)) begin
            count <= sat_inc(count);
        end
    end

    assign sel1_count = count;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1 at WIDTH=16: directed cases then random traffic vs a word-level model.
// Counter checks are compiled in when MUX2_1_SEL_COUNT_EN is defined.
module tb_mux_2to1;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic         sel = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         sel_q;
`ifdef MUX2_1_SEL_COUNT_EN
    logic [15:0]  sel1_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what the registered outputs must show after each edge.
    logic [W-1:0] exp_q = '0;
    logic         exp_sel = 1'b0;
    int           exp_cnt = 0;

    mux_2to1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .sel   (sel),
        .load  (load),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
`ifdef MUX2_1_SEL_COUNT_EN
        ,
        .sel1_count (sel1_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational path, clock, then check the registers.
    task automatic cycle(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic l, input logic r);
        logic [W-1:0] pick;
        in0 = a; in1 = b; sel = s; load = l; reset = r;
        pick = s ? b : a;
        #1;
        chk("out", 32'(out), 32'(pick));
        @(posedge clk);
        if (r) begin
            exp_q = '0; exp_sel = 1'b0; exp_cnt = 0;
        end else if (l) begin
            exp_q = pick; exp_sel = s;
            if (s && exp_cnt < 65535) exp_cnt = exp_cnt + 1;
        end
        #1;
        chk("out_q", 32'(out_q), 32'(exp_q));
        chk("sel_q", 32'(sel_q), 32'(exp_sel));
`ifdef MUX2_1_SEL_COUNT_EN
        chk("sel1_count", 32'(sel1_count), 32'(exp_cnt));
`endif
    endtask

    initial begin
        // Directed combinational values, with reset held so registers stay known.
        cycle(16'hCA35, 16'hE6F2, 1'b0, 1'b0, 1'b1);
        cycle(16'hCA35, 16'hE6F2, 1'b1, 1'b0, 1'b1);
        cycle(16'h35CA, 16'h190D, 1'b0, 1'b0, 1'b1);
        cycle(16'h35CA, 16'h190D, 1'b1, 1'b0, 1'b1);

        // Reset with load and sel=1 for two edges: registers stay clear, out follows in1.
        cycle(16'hCA35, 16'hE6F2, 1'b1, 1'b1, 1'b1);
        cycle(16'hCA35, 16'hE6F2, 1'b1, 1'b1, 1'b1);

        // Load in1, then hold for three cycles while out tracks in0.
        cycle(16'hCA35, 16'hE6F2, 1'b1, 1'b1, 1'b0);
        chk("load_val", 32'(out_q), 32'h0000E6F2);
        for (int i = 0; i < 3; i++) cycle(16'hCA35, 16'hE6F2, 1'b0, 1'b0, 1'b0);
        chk("hold_val", 32'(out_q), 32'h0000E6F2);

        // Load and reset together: reset wins.
        cycle(16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1);
        chk("rst_prio", 32'(out_q), 32'h0);

`ifdef MUX2_1_SEL_COUNT_EN
        for (int i = 0; i < 5; i++) cycle(16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b0);
        chk("cnt_five", 32'(sel1_count), 32'd5);
        for (int i = 0; i < 65540; i++) cycle(16'(i), 16'(~i), 1'b1, 1'b1, 1'b0);
        chk("cnt_sat", 32'(sel1_count), 32'h0000FFFF);
        cycle(16'h0, 16'h0, 1'b1, 1'b1, 1'b1);
        chk("cnt_rst", 32'(sel1_count), 32'h0);
`endif

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            cycle(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
